// File: rtl/simon_pkg.sv
// Shared constants and helpers for the Simon game blocks.
// Holds the button count, button index width, default debounce window and a one-hot to index
// helper used by the press detector.
package simon_pkg;

  localparam int unsigned NUM_BTN             = 4;
  localparam int unsigned IDX_W               = 2;  // clog2(NUM_BTN)
  localparam int unsigned DEBOUNCE_MS_DEFAULT = 10;

  // Index of the set bit in a one-hot vector. OR-ing the indices of all set bits gives the
  // right answer for one-hot input without a priority chain.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_BTN-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (vec[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/simon_buttons_if.sv
// Press-event handshake between the button front end and the game core.
//   press_valid : a press event is pending (driven by master)
//   press_idx   : index of the pressed button, meaningful while press_valid=1 (master)
//   press_ready : the core accepts the pending event this cycle (slave)
interface simon_buttons_if;
  import simon_pkg::*;

  logic             press_valid;
  logic [IDX_W-1:0] press_idx;
  logic             press_ready;

  modport master (
    output press_valid,
    output press_idx,
    input  press_ready
  );

  modport slave (
    input  press_valid,
    input  press_idx,
    output press_ready
  );

endinterface

// File: rtl/debounce_cell.sv
// Single-button synchroniser and debouncer.
//   clk, rst   : system clock, synchronous active-high reset
//   btn_raw    : asynchronous button pin
//   ms_tick    : one-cycle millisecond strobe from the shared prescaler
//   level      : debounced level (registered)
//   level_next : value level takes at the next edge
//   rose       : level is about to go 0 -> 1 at the next edge
// A changed input must stay stable for DEBOUNCE_MS consecutive ticks before level follows it;
// any return to the current level restarts the window.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned MS_W        = 5   // 2**MS_W must exceed DEBOUNCE_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic ms_tick,
  output logic level,
  output logic level_next,
  output logic rose
);

  localparam logic [MS_W-1:0] CntMax = MS_W'(DEBOUNCE_MS - 1);

  logic [1:0]      sync_q;
  logic            sync;
  logic            level_q, level_d;
  logic [MS_W-1:0] cnt_q, cnt_d;

  assign sync = sync_q[1];

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (ms_tick) begin
      if (cnt_q == CntMax) begin
        level_d = sync;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign level_next = level_d;
  assign rose       = level_d & ~level_q;

endmodule

// File: rtl/simon_buttons.sv
// Player-input front end for the Simon game.
//   clk, rst        : system clock, synchronous active-high reset
//   ticks_per_milli : clk cycles per millisecond (quasi-static)
//   btn_raw         : asynchronous active-high button pins
//   btn_level       : debounced button levels
//   press           : press-event handshake (valid/idx out, ready in)
//   conflict        : one-cycle pulse, a press was rejected because several buttons were down
//   overrun         : one-cycle pulse, a press was dropped because the slot was full
// Contains the millisecond prescaler, one debounce cell per button and a one-entry event slot.
// Every output comes straight from a flop.
module simon_buttons
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
  parameter int unsigned MS_W        = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            ticks_per_milli,
  input  logic [NUM_BTN-1:0]    btn_raw,
  output logic [NUM_BTN-1:0]    btn_level,
  simon_buttons_if.master       press,
  output logic                  conflict,
  output logic                  overrun
);

  // Millisecond prescaler. The >= compare also catches ticks_per_milli dropping below the
  // current count: the counter then wraps on the next edge with a tick.
  logic [5:0] ms_cnt_q, ms_cnt_d;
  logic       ms_tick;

  always_comb begin
    ms_tick  = (ticks_per_milli <= 6'd1) || (ms_cnt_q >= ticks_per_milli - 6'd1);
    ms_cnt_d = ms_tick ? 6'd0 : ms_cnt_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ms_cnt_q <= '0;
    else     ms_cnt_q <= ms_cnt_d;
  end

  logic [NUM_BTN-1:0] level_next;
  logic [NUM_BTN-1:0] rise;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .MS_W        (MS_W)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .ms_tick    (ms_tick),
      .level      (btn_level[i]),
      .level_next (level_next[i]),
      .rose       (rise[i])
    );
  end

  // A press is valid only if exactly one button rises and no other button is down after it.
  logic             rise_any, rise_onehot, valid_press;
  logic             press_valid_q, press_valid_d;
  logic [IDX_W-1:0] press_idx_q, press_idx_d;
  logic             conflict_q, conflict_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    rise_any      = |rise;
    rise_onehot   = rise_any && ((rise & (rise - 1'b1)) == '0);
    valid_press   = rise_onehot && (level_next == rise);
    conflict_d    = rise_any && !valid_press;
    overrun_d     = 1'b0;
    press_valid_d = press_valid_q;
    press_idx_d   = press_idx_q;
    if (valid_press && (!press_valid_q || press.press_ready)) begin
      press_valid_d = 1'b1;
      press_idx_d   = onehot_idx(rise);
    end else if (valid_press) begin
      overrun_d = 1'b1;  // slot full and not being drained: keep the older event
    end else if (press_valid_q && press.press_ready) begin
      press_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_valid_q <= 1'b0;
      press_idx_q   <= '0;
      conflict_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      press_valid_q <= press_valid_d;
      press_idx_q   <= press_idx_d;
      conflict_q    <= conflict_d;
      overrun_q     <= overrun_d;
    end
  end

  assign press.press_valid = press_valid_q;
  assign press.press_idx   = press_idx_q;
  assign conflict          = conflict_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_simon_buttons.sv
// Directed bench for simon_buttons with DEBOUNCE_MS=2 and, unless stated, ticks_per_milli=4.
module tb_simon_buttons;
  import simon_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] tpm = 6'd4;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_level;
  logic       conflict, overrun;

  simon_buttons_if bus ();

  simon_buttons #(
    .DEBOUNCE_MS (2),
    .MS_W        (5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (tpm),
    .btn_raw         (btn_raw),
    .btn_level       (btn_level),
    .press           (bus),
    .conflict        (conflict),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   conf_cnt = 0;
  int   ovr_cnt = 0;
  int   ev_cnt = 0;
  logic pv_prev = 1'b0;

  // Edge counter: first edge with rst low is cycle 1.
  always @(posedge clk) begin
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
  end

  // Pulse and event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (conflict === 1'b1) conf_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      if (bus.press_valid === 1'b1 && pv_prev !== 1'b1) ev_cnt++;
    end
    pv_prev = bus.press_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] raw, input logic [5:0] t);
    rst = 1'b1;
    btn_raw = raw;
    tpm = t;
    bus.press_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    conf_cnt = 0;
    ovr_cnt = 0;
    ev_cnt = 0;
  endtask

  task automatic pulse_ready();
    bus.press_ready = 1'b1;
    step();
    bus.press_ready = 1'b0;
  endtask

  // Steps until btn_level[i]==val; k is the number of edges taken, -1 on timeout.
  task automatic wait_level(input int i, input logic val, input int max, output int k);
    k = -1;
    for (int c = 1; c <= max; c++) begin
      step();
      if (btn_level[i] === val) begin
        k = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    int first;
    rst = 1'b1;
    btn_raw = 4'b1111;
    tpm = 6'd4;
    bus.press_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      outs = {btn_level, bus.press_valid, bus.press_idx, conflict, overrun};
      total++;
      if (outs !== 9'd0) begin
        bad++;
        $display("FAIL reset_hold: outputs got %b want 0", outs);
      end
    end
    rst = 1'b0;
    conf_cnt = 0;
    ev_cnt = 0;
    step();
    outs = {btn_level, bus.press_valid, bus.press_idx, conflict, overrun};
    total++;
    if (outs !== 9'd0) begin
      bad++;
      $display("FAIL reset_after: outputs got %b want 0", outs);
    end
    first = -1;
    for (int c = 2; c <= 14; c++) begin
      step();
      if (btn_level === 4'b1111 && first < 0) first = c;
    end
    total++;
    if (first < 7 || first > 11) begin
      bad++;
      $display("FAIL reset_level_latency: got %0d want 7..11", first);
    end
    total++;
    if (conf_cnt !== 1) begin
      bad++;
      $display("FAIL reset_conflict: got %0d pulses want 1", conf_cnt);
    end
    total++;
    if (ev_cnt !== 0 || bus.press_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_event: got ev=%0d valid=%b want 0 0", ev_cnt, bus.press_valid);
    end
  endtask

  task automatic test_clean_press();
    int  k;
    logic held;
    do_reset(4'b0000, 6'd4);
    btn_raw = 4'b0100;
    wait_level(2, 1'b1, 14, k);
    total++;
    if (k < 7 || k > 11) begin
      bad++;
      $display("FAIL press_latency: got %0d want 7..11", k);
    end
    total++;
    if (bus.press_valid !== 1'b1 || bus.press_idx !== 2'd2) begin
      bad++;
      $display("FAIL press_event: got v=%b idx=%0d want 1 2", bus.press_valid, bus.press_idx);
    end
    held = 1'b1;
    repeat (20) begin
      step();
      if (bus.press_valid !== 1'b1 || bus.press_idx !== 2'd2) held = 1'b0;
    end
    total++;
    if (held !== 1'b1) begin
      bad++;
      $display("FAIL press_hold: got %b want 1", held);
    end
    pulse_ready();
    total++;
    if (bus.press_valid !== 1'b0 || bus.press_idx !== 2'd2) begin
      bad++;
      $display("FAIL press_accept: got v=%b idx=%0d want 0 2", bus.press_valid, bus.press_idx);
    end
    btn_raw = 4'b0000;
    wait_level(2, 1'b0, 14, k);
    repeat (3) step();
    total++;
    if (k < 0 || ev_cnt !== 1 || conf_cnt !== 0 || bus.press_valid !== 1'b0) begin
      bad++;
      $display("FAIL release_quiet: got k=%0d ev=%0d conf=%0d v=%b want >0 1 0 0",
               k, ev_cnt, conf_cnt, bus.press_valid);
    end
  endtask

  task automatic test_bounce();
    int k;
    do_reset(4'b0000, 6'd4);
    btn_raw = 4'b0010;
    repeat (3) step();
    btn_raw = 4'b0000;
    repeat (2) step();
    btn_raw = 4'b0010;
    wait_level(1, 1'b1, 14, k);
    total++;
    if (k < 1 || k > 11) begin
      bad++;
      $display("FAIL bounce_latency: got %0d want 1..11", k);
    end
    repeat (2) step();
    total++;
    if (ev_cnt !== 1 || bus.press_valid !== 1'b1 || bus.press_idx !== 2'd1) begin
      bad++;
      $display("FAIL bounce_event: got ev=%0d v=%b idx=%0d want 1 1 1",
               ev_cnt, bus.press_valid, bus.press_idx);
    end
    pulse_ready();
    btn_raw = 4'b0000;
    wait_level(1, 1'b0, 14, k);
    btn_raw = 4'b0010;
    repeat (3) step();
    btn_raw = 4'b0000;
    repeat (15) step();
    total++;
    if (btn_level !== 4'b0000 || ev_cnt !== 1 || bus.press_valid !== 1'b0) begin
      bad++;
      $display("FAIL glitch_ignored: got lvl=%b ev=%0d v=%b want 0000 1 0",
               btn_level, ev_cnt, bus.press_valid);
    end
  endtask

  task automatic test_chord();
    int k;
    do_reset(4'b0000, 6'd4);
    btn_raw = 4'b1001;
    repeat (14) step();
    total++;
    if (btn_level !== 4'b1001 || conf_cnt !== 1 || ev_cnt !== 0 || bus.press_valid !== 1'b0) begin
      bad++;
      $display("FAIL chord_same_cycle: got lvl=%b conf=%0d ev=%0d v=%b want 1001 1 0 0",
               btn_level, conf_cnt, ev_cnt, bus.press_valid);
    end
    btn_raw = 4'b0000;
    repeat (14) step();
    total++;
    if (btn_level !== 4'b0000 || conf_cnt !== 1) begin
      bad++;
      $display("FAIL chord_release: got lvl=%b conf=%0d want 0000 1", btn_level, conf_cnt);
    end
    btn_raw = 4'b0001;
    wait_level(0, 1'b1, 14, k);
    total++;
    if (bus.press_valid !== 1'b1 || bus.press_idx !== 2'd0) begin
      bad++;
      $display("FAIL chord_first: got v=%b idx=%0d want 1 0", bus.press_valid, bus.press_idx);
    end
    pulse_ready();
    btn_raw = 4'b1001;
    wait_level(3, 1'b1, 14, k);
    total++;
    if (k < 0 || conflict !== 1'b1) begin
      bad++;
      $display("FAIL chord_held_conflict: got k=%0d conflict=%b want >0 1", k, conflict);
    end
    step();
    total++;
    if (conflict !== 1'b0 || conf_cnt !== 2 || ev_cnt !== 1 || bus.press_valid !== 1'b0) begin
      bad++;
      $display("FAIL chord_held_after: got c=%b conf=%0d ev=%0d v=%b want 0 2 1 0",
               conflict, conf_cnt, ev_cnt, bus.press_valid);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int m;
    int pred;
    do_reset(4'b0000, 6'd4);
    btn_raw = 4'b0010;
    wait_level(1, 1'b1, 14, k);
    btn_raw = 4'b0000;
    wait_level(1, 1'b0, 14, k);
    btn_raw = 4'b0100;
    wait_level(2, 1'b1, 14, k);
    total++;
    if (overrun !== 1'b1 || bus.press_valid !== 1'b1 || bus.press_idx !== 2'd1) begin
      bad++;
      $display("FAIL overrun_pulse: got o=%b v=%b idx=%0d want 1 1 1",
               overrun, bus.press_valid, bus.press_idx);
    end
    step();
    total++;
    if (overrun !== 1'b0 || ovr_cnt !== 1 || bus.press_idx !== 2'd1) begin
      bad++;
      $display("FAIL overrun_after: got o=%b cnt=%0d idx=%0d want 0 1 1",
               overrun, ovr_cnt, bus.press_idx);
    end
    pulse_ready();
    btn_raw = 4'b0000;
    wait_level(2, 1'b0, 14, k);
    btn_raw = 4'b0010;
    wait_level(1, 1'b1, 14, k);
    btn_raw = 4'b0000;
    wait_level(1, 1'b0, 14, k);
    // Predict the edge btn 2's level rises: ticks act on edges that are multiples of 4.
    btn_raw = 4'b0100;
    m = cyc + 3;
    while (m % 4 != 0) m++;
    pred = m + 4;
    for (int c = 0; c < 20 && cyc < pred - 1; c++) step();
    pulse_ready();
    total++;
    if (btn_level[2] !== 1'b1 || bus.press_valid !== 1'b1 || bus.press_idx !== 2'd2 ||
        overrun !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back: got lvl=%b v=%b idx=%0d o=%b want 1 1 2 0",
               btn_level[2], bus.press_valid, bus.press_idx, overrun);
    end
    step();
    total++;
    if (bus.press_valid !== 1'b1 || bus.press_idx !== 2'd2 || ovr_cnt !== 1) begin
      bad++;
      $display("FAIL back_to_back_hold: got v=%b idx=%0d ovr=%0d want 1 2 1",
               bus.press_valid, bus.press_idx, ovr_cnt);
    end
  endtask

  task automatic test_tick_rate();
    int k;
    for (int t = 0; t < 2; t++) begin
      do_reset(4'b0000, 6'(t));
      btn_raw = 4'b0001;
      wait_level(0, 1'b1, 14, k);
      total++;
      if (k < 1 || k > 5 || bus.press_valid !== 1'b1 || bus.press_idx !== 2'd0) begin
        bad++;
        $display("FAIL fast_tick_t%0d: got k=%0d v=%b want 1..5 1", t, k, bus.press_valid);
      end
    end
    do_reset(4'b0000, 6'd4);
    repeat (5) step();
    btn_raw = 4'b0001;
    repeat (2) step();
    tpm = 6'd2;
    step();
    step();
    total++;
    if (btn_level[0] !== 1'b0) begin
      bad++;
      $display("FAIL t_change_early: got %b want 0 at cycle %0d", btn_level[0], cyc);
    end
    step();
    total++;
    if (btn_level[0] !== 1'b1 || bus.press_valid !== 1'b1) begin
      bad++;
      $display("FAIL t_change_wrap: got lvl=%b v=%b want 1 1 at cycle %0d",
               btn_level[0], bus.press_valid, cyc);
    end
  endtask

  initial begin
    bus.press_ready = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_chord();
    test_back_to_back();
    test_tick_rate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
